// File: rtl/lcd_pkg.sv
// Shared constants, page layout indices and helpers for the LCD text path.
package lcd_pkg;

  localparam int unsigned VALUE_W = 8;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned CNT_W   = 3;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_U     = 8'h55;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_X     = 8'h58;

  localparam logic [IDX_W-1:0] IDX_SIGN = 5'd5;
  localparam logic [IDX_W-1:0] IDX_DEC  = 5'd6;
  localparam logic [IDX_W-1:0] IDX_HEX  = 5'd20;
  localparam logic [IDX_W-1:0] IDX_BIN  = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  // Nibble to ASCII; also used for decimal digits, which never exceed 9.
  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? ASCII_ZERO + 8'(d) : ASCII_A + 8'(d - 4'd10);
  endfunction

  // 8'h80 negates to itself, which reads as 128 unsigned.
  function automatic logic [VALUE_W-1:0] magnitude(input logic [VALUE_W-1:0] v,
                                                   input logic is_signed);
    return (is_signed && v[VALUE_W-1]) ? VALUE_W'(-v) : v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit double-dabble: one add-3/shift step per cycle, 8 steps per start.
module bin2bcd_seq
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [VALUE_W-1:0] bin,
  output logic               done_c,
  output logic [BCD_W-1:0]   bcd
);

  logic [VALUE_W-1:0]       shreg;
  logic [CNT_W-1:0]         cnt;
  logic                     active;
  logic [BCD_W-1:0]         adj_c;
  logic [BCD_W+VALUE_W-1:0] shift_c;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign adj_c   = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign shift_c = {adj_c, shreg} << 1;
  // High during the final step, so the caller can commit on the following edge.
  assign done_c  = active && (cnt == CNT_W'(7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      shreg  <= bin;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      {bcd, shreg} <= shift_c;
      cnt          <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(7)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_value_formatter.sv
// Captures a byte, converts it to decimal in the background and serves a 2x16 ASCII page
// built only from committed registers.
module lcd_value_formatter
  import lcd_pkg::*;
#(
  parameter bit SIGNED      = 1'b0,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [VALUE_W-1:0] iVALUE,
  input  logic               iVALID,
  input  logic [IDX_W-1:0]   iMSG_INDEX,
  output logic [7:0]         oMSG_ASCII,
  output logic               oBUSY,
  output logic               oDONE
);

  state_e             state;
  logic               pend_valid;
  logic [VALUE_W-1:0] pend_value;
  logic [VALUE_W-1:0] conv_value;
  logic               conv_neg;
  logic [VALUE_W-1:0] com_value;
  logic               com_neg;
  logic [BCD_W-1:0]   com_bcd;
  logic [BCD_W-1:0]   conv_bcd;
  logic               conv_done_c;
  logic               start_c;
  logic [VALUE_W-1:0] start_val_c;
  logic [7:0]         char_c;
  logic [2:0]         bit_sel_c;
  logic [3:0]         hund, tens, units;

  assign hund  = com_bcd[11:8];
  assign tens  = com_bcd[7:4];
  assign units = com_bcd[3:0];

  bin2bcd_seq u_bin2bcd (
    .clk    (iCLK),
    .rst_n  (iRST_N),
    .start  (start_c),
    .bin    (magnitude(start_val_c, SIGNED)),
    .done_c (conv_done_c),
    .bcd    (conv_bcd)
  );

  // Start source: a fresh strobe beats an older pending value.
  always_comb begin
    start_c     = 1'b0;
    start_val_c = iVALUE;
    case (state)
      ST_IDLE: begin
        if (iVALID) begin
          start_c = 1'b1;
        end else if (pend_valid) begin
          start_c     = 1'b1;
          start_val_c = pend_value;
        end
      end
      ST_COMMIT: begin
        if (pend_valid) begin
          start_c = 1'b1;
          if (!iVALID) start_val_c = pend_value;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= ST_IDLE;
      pend_valid <= 1'b0;
      pend_value <= '0;
      conv_value <= '0;
      conv_neg   <= 1'b0;
      com_value  <= '0;
      com_neg    <= 1'b0;
      com_bcd    <= '0;
      oMSG_ASCII <= ASCII_SPACE;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
    end else begin
      oDONE      <= 1'b0;
      oMSG_ASCII <= char_c;
      if (start_c) begin
        conv_value <= start_val_c;
        conv_neg   <= SIGNED && start_val_c[VALUE_W-1];
      end
      case (state)
        ST_IDLE: begin
          oBUSY <= start_c;
          if (start_c) begin
            state      <= ST_SHIFT;
            pend_valid <= 1'b0;
          end
        end
        ST_SHIFT: begin
          oBUSY <= 1'b1;
          if (iVALID) begin
            pend_valid <= 1'b1;
            pend_value <= iVALUE;
          end
          if (conv_done_c) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          com_value <= conv_value;
          com_neg   <= conv_neg;
          com_bcd   <= conv_bcd;
          oDONE     <= 1'b1;
          oBUSY     <= start_c || iVALID;
          if (start_c) begin
            state      <= ST_SHIFT;
            pend_valid <= 1'b0;
          end else begin
            state <= ST_IDLE;
            if (iVALID) begin
              pend_valid <= 1'b1;
              pend_value <= iVALUE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

  // Character mux over the committed value.
  always_comb begin
    char_c    = ASCII_SPACE;
    bit_sel_c = 3'(IDX_BIN + 5'd7 - iMSG_INDEX);
    case (iMSG_INDEX)
      5'd0:            char_c = ASCII_O;
      5'd1:            char_c = ASCII_U;
      5'd2:            char_c = ASCII_T;
      5'd3:            char_c = ASCII_COLON;
      5'd16:           char_c = ASCII_H;
      5'd17:           char_c = ASCII_E;
      5'd18:           char_c = ASCII_X;
      5'd19:           char_c = ASCII_COLON;
      IDX_SIGN:        if (com_neg) char_c = ASCII_MINUS;
      IDX_DEC:         if (!(BLANK_ZEROS && hund == 4'd0)) char_c = hex_char(hund);
      IDX_DEC + 5'd1:  if (!(BLANK_ZEROS && hund == 4'd0 && tens == 4'd0)) char_c = hex_char(tens);
      IDX_DEC + 5'd2:  char_c = hex_char(units);
      IDX_HEX:         char_c = hex_char(com_value[7:4]);
      IDX_HEX + 5'd1:  char_c = hex_char(com_value[3:0]);
      default: begin
        if (iMSG_INDEX >= IDX_BIN && iMSG_INDEX <= IDX_BIN + 5'd7)
          char_c = com_value[bit_sel_c] ? ASCII_ONE : ASCII_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Directed bench for lcd_value_formatter: unsigned and signed instances share stimulus.
module tb_lcd_value_formatter;

  logic       clk;
  logic       rst_n;
  logic [7:0] value;
  logic       valid;
  logic [4:0] idx;
  logic [7:0] ascii_u, ascii_s;
  logic       busy_u, busy_s, done_u, done_s;

  int n_checks = 0;
  int n_errors = 0;

  localparam string PG_RESET = "OUT:    0       HEX:00 00000000 ";
  localparam string PG_A5_U  = "OUT:  165       HEX:A5 10100101 ";
  localparam string PG_A5_S  = "OUT: - 91       HEX:A5 10100101 ";
  localparam string PG_80_U  = "OUT:  128       HEX:80 10000000 ";
  localparam string PG_80_S  = "OUT: -128       HEX:80 10000000 ";
  localparam string PG_FF_U  = "OUT:  255       HEX:FF 11111111 ";
  localparam string PG_FF_S  = "OUT: -  1       HEX:FF 11111111 ";
  localparam string PG_05    = "OUT:    5       HEX:05 00000101 ";
  localparam string PG_2A    = "OUT:   42       HEX:2A 00101010 ";
  localparam string PG_01    = "OUT:    1       HEX:01 00000001 ";
  localparam string PG_3C    = "OUT:   60       HEX:3C 00111100 ";

  lcd_value_formatter #(.SIGNED(1'b0), .BLANK_ZEROS(1'b1)) u_dut_u (
    .iCLK(clk), .iRST_N(rst_n), .iVALUE(value), .iVALID(valid), .iMSG_INDEX(idx),
    .oMSG_ASCII(ascii_u), .oBUSY(busy_u), .oDONE(done_u)
  );

  lcd_value_formatter #(.SIGNED(1'b1), .BLANK_ZEROS(1'b1)) u_dut_s (
    .iCLK(clk), .iRST_N(rst_n), .iVALUE(value), .iVALID(valid), .iMSG_INDEX(idx),
    .oMSG_ASCII(ascii_s), .oBUSY(busy_s), .oDONE(done_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One char per cycle: index driven at a negedge, registered char sampled at the next.
  task automatic sweep(input bit sel_s, input string tag, input string page);
    logic [7:0] ch;
    for (int i = 0; i < 32; i++) begin
      idx = 5'(i);
      @(negedge clk);
      ch = page.getc(i);
      check($sformatf("%s[%0d]", tag, i), sel_s ? ascii_s : ascii_u, ch);
    end
  endtask

  task automatic pulse_valid(input logic [7:0] v);
    @(negedge clk);
    value = v;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_u && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic convert(input logic [7:0] v, input string tag,
                         input string page_u, input string page_s);
    int n;
    pulse_valid(v);
    check({tag, "_busy_rise"}, busy_u, 1'b1);
    wait_done(n);
    check({tag, "_latency"}, n, 9);
    check({tag, "_done_s"}, done_s, 1'b1);
    @(negedge clk);
    check({tag, "_done_pulse"}, done_u, 1'b0);
    check({tag, "_busy_fall"}, busy_u, 1'b0);
    sweep(1'b0, {tag, "_u"}, page_u);
    sweep(1'b1, {tag, "_s"}, page_s);
  endtask

  initial begin
    int ndone, d1, d2, first_idle;
    rst_n = 1'b0;
    valid = 1'b0;
    value = 8'h00;
    idx   = 5'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ascii", ascii_u, 8'h20);
    check("rst_busy", busy_u, 1'b0);
    check("rst_done", done_u, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(1'b0, "reset_u", PG_RESET);
    sweep(1'b1, "reset_s", PG_RESET);
    check("reset_busy_s", busy_s, 1'b0);

    // Basic conversions and sign / blanking corners
    convert(8'hA5, "a5", PG_A5_U, PG_A5_S);
    convert(8'h80, "x80", PG_80_U, PG_80_S);
    convert(8'hFF, "ff", PG_FF_U, PG_FF_S);
    convert(8'h05, "x05", PG_05, PG_05);

    // Two strobes during SHIFT: only the latest survives as pending
    pulse_valid(8'h07);
    ndone = 0; d1 = -1; d2 = -1; first_idle = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      valid = (n == 2) || (n == 4);
      value = (n == 2) ? 8'h10 : 8'h2A;
      if (done_u) begin
        ndone++;
        if (ndone == 1) d1 = n;
        if (ndone == 2) d2 = n;
      end
      if (!busy_u && first_idle < 0) first_idle = n;
    end
    valid = 1'b0;
    check("pend_ndone", ndone, 2);
    check("pend_d1", d1, 9);
    check("pend_d2", d2, 18);
    check("pend_idle", first_idle, 18);
    sweep(1'b0, "pend_u", PG_2A);
    sweep(1'b1, "pend_s", PG_2A);

    // Reset mid-SHIFT aborts without a commit
    pulse_valid(8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 2) rst_n = 1'b1;
      if (done_u || done_s) ndone++;
    end
    check("abort_ndone", ndone, 0);
    check("abort_busy", busy_u, 1'b0);
    sweep(1'b0, "abort_u", PG_RESET);
    sweep(1'b1, "abort_s", PG_RESET);
    convert(8'h01, "x01", PG_01, PG_01);

    // Reads during conversion see the old page until the commit, then the new one
    pulse_valid(8'h3C);
    for (int n = 0; n < 20; n++) begin
      logic [7:0] ch;
      string pg;
      idx = 5'((n * 7 + 3) % 32);
      @(negedge clk);
      pg = (n + 1 >= 10) ? PG_3C : PG_01;
      ch = pg.getc(int'(idx));
      check($sformatf("atomic_u[%0d]", n), ascii_u, ch);
      check($sformatf("atomic_s[%0d]", n), ascii_s, ch);
    end
    check("atomic_busy", busy_u, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
